pipeline_memory_responder: RTL and testbench



---
 rtl/pipeline_memory_responder.sv | 108 ++++++++++
 tb/tb_pipeline_memory_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_memory_responder.sv
// Memory-side responder for the ifetch and dcache ports.
// Line-organized RAM with one-cycle registered responses and sticky status.

`ifndef CACHE_LINE_BITS
`define CACHE_LINE_BITS 512
`endif
`ifndef CACHE_LINE_BYTES
`define CACHE_LINE_BYTES 64
`endif

module pipeline_memory_responder #(
  parameter int unsigned LINE_COUNT = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   icache_request_addr,
  output logic [31:0]                   icache_data,
  input  logic [31:0]                   dcache_request_addr,
  input  logic                          dcache_read_en,
  output logic [`CACHE_LINE_BITS-1:0]   dcache_read_data,
  input  logic                          dcache_write_en,
  input  logic [`CACHE_LINE_BITS-1:0]   dcache_write_data,
  input  logic [`CACHE_LINE_BYTES-1:0]  dcache_write_mask,
  output logic                          addr_error,
  output logic [31:0]                   dcache_read_count,
  output logic [31:0]                   dcache_write_count
);

  localparam int unsigned LineBits  = `CACHE_LINE_BITS;
  localparam int unsigned LineBytes = `CACHE_LINE_BYTES;
  localparam int unsigned IdxW      = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;

  logic [LineBits-1:0] mem_q [LINE_COUNT];

  logic [31:0]         icache_data_q, icache_data_d;
  logic [LineBits-1:0] read_data_q, read_data_d;
  logic                addr_error_q, addr_error_d;
  logic [31:0]         read_count_q, read_count_d;
  logic [31:0]         write_count_q, write_count_d;

  logic [IdxW-1:0]     i_idx, d_idx;
  logic                i_ok, d_ok;
  logic [LineBits-1:0] i_line;

  // Low address bits below the line/word granularity carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dcache_request_addr[5:0], icache_request_addr[1:0]};

  always_comb begin
    i_ok  = ({6'b0, icache_request_addr[31:6]} < LINE_COUNT);
    d_ok  = ({6'b0, dcache_request_addr[31:6]} < LINE_COUNT);
    i_idx = icache_request_addr[6 +: IdxW];
    d_idx = dcache_request_addr[6 +: IdxW];

    i_line        = mem_q[i_idx];
    icache_data_d = i_ok ? i_line[{icache_request_addr[5:2], 5'b0} +: 32] : '0;

    read_data_d = read_data_q;
    if (dcache_read_en) begin
      read_data_d = d_ok ? mem_q[d_idx] : '0;
    end

    addr_error_d = addr_error_q | ~i_ok | (~d_ok & (dcache_read_en | dcache_write_en));

    read_count_d = read_count_q;
    if (dcache_read_en && (read_count_q != '1)) begin
      read_count_d = read_count_q + 32'd1;
    end
    write_count_d = write_count_q;
    if (dcache_write_en && (write_count_q != '1)) begin
      write_count_d = write_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icache_data_q <= '0;
      read_data_q   <= '0;
      addr_error_q  <= 1'b0;
      read_count_q  <= '0;
      write_count_q <= '0;
    end else begin
      icache_data_q <= icache_data_d;
      read_data_q   <= read_data_d;
      addr_error_q  <= addr_error_d;
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
    end
  end

  // RAM contents survive reset; reads above see pre-write data at the same edge.
  always_ff @(posedge clk) begin
    if (dcache_write_en && d_ok) begin
      for (int b = 0; b < LineBytes; b++) begin
        if (dcache_write_mask[b]) begin
          mem_q[d_idx][8*b +: 8] <= dcache_write_data[8*b +: 8];
        end
      end
    end
  end

  assign icache_data        = icache_data_q;
  assign dcache_read_data   = read_data_q;
  assign addr_error         = addr_error_q;
  assign dcache_read_count  = read_count_q;
  assign dcache_write_count = write_count_q;

endmodule

// File: tb/tb_pipeline_memory_responder.sv
// Directed self-checking bench for pipeline_memory_responder (LINE_COUNT = 256).

`ifndef CACHE_LINE_BITS
`define CACHE_LINE_BITS 512
`endif
`ifndef CACHE_LINE_BYTES
`define CACHE_LINE_BYTES 64
`endif

module tb_pipeline_memory_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  icache_request_addr;
  logic [31:0]  icache_data;
  logic [31:0]  dcache_request_addr;
  logic         dcache_read_en;
  logic [511:0] dcache_read_data;
  logic         dcache_write_en;
  logic [511:0] dcache_write_data;
  logic [63:0]  dcache_write_mask;
  logic         addr_error;
  logic [31:0]  dcache_read_count;
  logic [31:0]  dcache_write_count;

  int total = 0;
  int bad   = 0;

  logic [511:0] words_line, masked_line;

  pipeline_memory_responder #(.LINE_COUNT(256)) dut (
    .clk                (clk),
    .reset              (reset),
    .icache_request_addr(icache_request_addr),
    .icache_data        (icache_data),
    .dcache_request_addr(dcache_request_addr),
    .dcache_read_en     (dcache_read_en),
    .dcache_read_data   (dcache_read_data),
    .dcache_write_en    (dcache_write_en),
    .dcache_write_data  (dcache_write_data),
    .dcache_write_mask  (dcache_write_mask),
    .addr_error         (addr_error),
    .dcache_read_count  (dcache_read_count),
    .dcache_write_count (dcache_write_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dcache_read_en    = 1'b0;
    dcache_write_en   = 1'b0;
    dcache_write_mask = '0;
  endtask

  function automatic logic [511:0] fill(input logic [7:0] b);
    return {64{b}};
  endfunction

  initial begin
    reset               = 1'b0;
    icache_request_addr = 32'h0;
    dcache_request_addr = 32'h0;
    dcache_write_data   = '0;
    idle();
    for (int w = 0; w < 16; w++) words_line[32*w +: 32] = 32'h1000_0000 + w;
    masked_line = fill(8'h11);
    for (int i = 4; i < 8; i++) masked_line[8*i +: 8] = 8'(i);

    #3;
    chk("por_icache", {480'b0, icache_data}, '0);
    chk("por_rdata", dcache_read_data, '0);
    chk("por_err", {511'b0, addr_error}, '0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Preload lines 0, 1, 2
    dcache_write_en = 1'b1; dcache_write_mask = '1;
    dcache_request_addr = 32'h00; dcache_write_data = words_line; tick();
    dcache_request_addr = 32'h40; dcache_write_data = fill(8'h11); tick();
    dcache_request_addr = 32'h80; dcache_write_data = fill(8'hAA); tick();
    idle();
    dcache_read_en = 1'b1; dcache_request_addr = 32'h40; icache_request_addr = 32'h0; tick();
    idle();
    chk("pre_icache", {480'b0, icache_data}, {480'b0, 32'h1000_0000});
    chk("pre_rdata", dcache_read_data, fill(8'h11));
    chk("pre_wcnt", {480'b0, dcache_write_count}, 512'd3);
    chk("pre_rcnt", {480'b0, dcache_read_count}, 512'd1);

    // Asynchronous reset with no clock edge
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rst_icache", {480'b0, icache_data}, '0);
    chk("rst_rdata", dcache_read_data, '0);
    chk("rst_wcnt", {480'b0, dcache_write_count}, '0);
    chk("rst_rcnt", {480'b0, dcache_read_count}, '0);
    chk("rst_err", {511'b0, addr_error}, '0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Masked write then read
    dcache_write_en = 1'b1; dcache_request_addr = 32'h40;
    dcache_write_mask = 64'h0000_0000_0000_00F0;
    for (int i = 0; i < 64; i++) dcache_write_data[8*i +: 8] = 8'(i);
    tick();
    idle();
    dcache_read_en = 1'b1; tick();
    idle();
    chk("mask_rdata", dcache_read_data, masked_line);
    chk("mask_wcnt", {480'b0, dcache_write_count}, 512'd1);
    chk("mask_rcnt", {480'b0, dcache_read_count}, 512'd1);

    // Same-cycle collision on line 2
    dcache_request_addr = 32'h80; dcache_write_data = fill(8'h55);
    dcache_write_en = 1'b1; dcache_write_mask = '1; dcache_read_en = 1'b1;
    icache_request_addr = 32'h84;
    tick();
    idle();
    chk("coll_rdata", dcache_read_data, fill(8'hAA));
    chk("coll_icache", {480'b0, icache_data}, {480'b0, 32'hAAAA_AAAA});
    dcache_read_en = 1'b1; tick();
    idle();
    chk("coll_after_rdata", dcache_read_data, fill(8'h55));
    chk("coll_after_icache", {480'b0, icache_data}, {480'b0, 32'h5555_5555});

    // Instruction word select; read_data must hold with read_en low
    icache_request_addr = 32'h3C; tick();
    chk("ifetch_3c", {480'b0, icache_data}, {480'b0, 32'h1000_000F});
    chk("rdata_hold", dcache_read_data, fill(8'h55));
    icache_request_addr = 32'h00; tick();
    chk("ifetch_00", {480'b0, icache_data}, {480'b0, 32'h1000_0000});
    chk("err_clear", {511'b0, addr_error}, '0);

    // Out of range
    dcache_request_addr = 32'h4000; dcache_read_en = 1'b1; tick();
    idle();
    chk("oob_rdata", dcache_read_data, '0);
    chk("oob_err", {511'b0, addr_error}, 512'd1);
    chk("oob_rcnt", {480'b0, dcache_read_count}, 512'd4);
    dcache_write_en = 1'b1; dcache_write_mask = '1; dcache_write_data = fill(8'hFF); tick();
    idle();
    chk("oob_wcnt", {480'b0, dcache_write_count}, 512'd3);
    dcache_request_addr = 32'h0; dcache_read_en = 1'b1; tick();
    idle();
    chk("oob_line0", dcache_read_data, words_line);
    chk("oob_err_sticky", {511'b0, addr_error}, 512'd1);
    icache_request_addr = 32'h4000; tick();
    icache_request_addr = 32'h0;
    chk("oob_icache", {480'b0, icache_data}, '0);

    // Counter saturation
    force dut.read_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.read_count_q;
    dcache_read_en = 1'b1;
    tick();
    chk("sat_1", {480'b0, dcache_read_count}, {480'b0, 32'hFFFF_FFFF});
    tick();
    chk("sat_2", {480'b0, dcache_read_count}, {480'b0, 32'hFFFF_FFFF});
    tick();
    chk("sat_3", {480'b0, dcache_read_count}, {480'b0, 32'hFFFF_FFFF});
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
